// File: rtl/adc_decim_pkg.sv
// Shared types and helpers for the ADC boxcar decimator.
package adc_decim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned max_log2);
    return data_width + max_log2;
  endfunction

  function automatic logic [3:0] clamp_log2(input logic [3:0]  l,
                                            input int unsigned max_l);
    return (32'(l) > max_l) ? 4'(max_l) : l;
  endfunction

endpackage

// File: rtl/adc_boxcar_accum.sv
// Boxcar accumulator: sums 2^L signed samples and pulses the floored mean on the closing sample.
module adc_boxcar_accum
  import adc_decim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned MAX_LOG2_DECIM = 8,
  parameter int unsigned ACC_WIDTH      = acc_width(DATA_WIDTH, MAX_LOG2_DECIM)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         valid_i,
  input  logic [3:0]                   log2_i,
  output logic signed [ACC_WIDTH-1:0]  result_o,
  output logic                         result_valid_o
);

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, sum;
  logic [MAX_LOG2_DECIM-1:0]    cnt_q, cnt_d, last_idx;
  logic                         closing;

  assign sum            = acc_q + ACC_WIDTH'(sample_i);
  assign last_idx       = MAX_LOG2_DECIM'((32'd1 << log2_i) - 32'd1);
  assign closing        = valid_i && !clr_i && (cnt_q == last_idx);
  // Result is combinational so the top registers it on the closing edge.
  assign result_o       = sum >>> log2_i;
  assign result_valid_o = closing;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i || closing) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (valid_i) begin
      acc_d = sum;
      cnt_d = cnt_q + MAX_LOG2_DECIM'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_adc_decimator.sv
// ADC stream decimator with single-entry AXI-Stream output, packet tlast and sticky overrun.
// Optional ADC_DECIM_STATS_EN adds a saturating drop_count output.
module axis_adc_decimator
  import adc_decim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned MAX_LOG2_DECIM = 8,
  parameter int unsigned PKT_LEN_WIDTH  = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cfg_enable,
  input  logic [3:0]               cfg_log2_decim,
  input  logic [PKT_LEN_WIDTH-1:0] cfg_pkt_len,
  input  logic [31:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     overrun
`ifdef ADC_DECIM_STATS_EN
  ,
  output logic [31:0]              drop_count
`endif
);

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, MAX_LOG2_DECIM);

  state_e                     state_q, state_d;
  logic                       en_q;
  logic [3:0]                 log2_q, log2_d;
  logic [PKT_LEN_WIDTH-1:0]   pkt_len_q, pkt_len_d, beat_q, beat_d;
  logic [31:0]                tdata_q, tdata_d;
  logic                       tvalid_q, tvalid_d, tlast_q, tlast_d, overrun_q, overrun_d;
  logic                       run_active, handshake, res_valid, load_last;
  logic signed [ACC_WIDTH-1:0] res;
  logic                       unused_tdata_hi;
`ifdef ADC_DECIM_STATS_EN
  logic [31:0]                drops_q, drops_d;
`endif

  assign unused_tdata_hi = ^s_axis_tdata[31:DATA_WIDTH];
  assign s_axis_tready   = !areset;
  // Samples only count while RUN is held enabled, so a window can't close during the stop cycle.
  assign run_active      = (state_q == RUN) && cfg_enable;
  assign handshake       = tvalid_q && m_axis_tready;
  assign load_last       = (beat_q == pkt_len_q - PKT_LEN_WIDTH'(1));

  adc_boxcar_accum #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_LOG2_DECIM(MAX_LOG2_DECIM),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_accum (
    .clk_i         (aclk),
    .rst_i         (areset),
    .clr_i         (!run_active),
    .sample_i      (s_axis_tdata[DATA_WIDTH-1:0]),
    .valid_i       (s_axis_tvalid && run_active),
    .log2_i        (log2_q),
    .result_o      (res),
    .result_valid_o(res_valid)
  );

  always_comb begin
    state_d   = state_q;
    log2_d    = log2_q;
    pkt_len_d = pkt_len_q;
    beat_d    = beat_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    overrun_d = overrun_q;
`ifdef ADC_DECIM_STATS_EN
    drops_d   = drops_q;
`endif
    if (handshake) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (res_valid) begin
      if (!tvalid_q || handshake) begin
        tdata_d  = 32'(res);
        tvalid_d = 1'b1;
        tlast_d  = load_last;
        beat_d   = load_last ? '0 : beat_q + PKT_LEN_WIDTH'(1);
      end else begin
        overrun_d = 1'b1;
`ifdef ADC_DECIM_STATS_EN
        if (drops_q != '1) drops_d = drops_q + 32'd1;
`endif
      end
    end
    case (state_q)
      IDLE: begin
        if (cfg_enable && !en_q) begin
          state_d   = RUN;
          log2_d    = clamp_log2(cfg_log2_decim, MAX_LOG2_DECIM);
          pkt_len_d = (cfg_pkt_len == '0) ? PKT_LEN_WIDTH'(1) : cfg_pkt_len;
          beat_d    = '0;
          overrun_d = 1'b0;
`ifdef ADC_DECIM_STATS_EN
          drops_d   = '0;
`endif
        end
      end
      RUN:     if (!cfg_enable) state_d = (tvalid_q && !m_axis_tready) ? DRAIN : IDLE;
      DRAIN:   if (!tvalid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      log2_q    <= '0;
      pkt_len_q <= PKT_LEN_WIDTH'(1);
      beat_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef ADC_DECIM_STATS_EN
      drops_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= cfg_enable;
      log2_q    <= log2_d;
      pkt_len_q <= pkt_len_d;
      beat_q    <= beat_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      overrun_q <= overrun_d;
`ifdef ADC_DECIM_STATS_EN
      drops_q   <= drops_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overrun       = overrun_q;
`ifdef ADC_DECIM_STATS_EN
  assign drop_count    = drops_q;
`endif

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Self-checking bench for axis_adc_decimator: windowed-mean reference model plus directed literal checks.
module tb_axis_adc_decimator;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [3:0]  cfg_log2_decim = '0;
  logic [15:0] cfg_pkt_len = '0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        overrun;
`ifdef ADC_DECIM_STATS_EN
  logic [31:0] drop_count;
`endif

  always #5 aclk = ~aclk;

  axis_adc_decimator #(
    .DATA_WIDTH    (18),
    .MAX_LOG2_DECIM(8),
    .PKT_LEN_WIDTH (16)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_enable    (cfg_enable),
    .cfg_log2_decim(cfg_log2_decim),
    .cfg_pkt_len   (cfg_pkt_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overrun       (overrun)
`ifdef ADC_DECIM_STATS_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=drain, window tracked as running sum and count.
  int          md_mode = 0;
  bit          md_pen = 0;
  int          md_l = 0;
  int          md_pkt = 1;
  int          md_beat = 0;
  longint      md_sum = 0;
  int          md_n = 0;
  bit          md_ov = 0;
  logic [31:0] md_od = '0;
  bit          md_ol = 0;
  bit          md_ovr = 0;
  longint      md_drops = 0;
  logic [31:0] dlv_data[$];
  bit          dlv_last[$];

  function automatic longint sx18(input logic [31:0] w);
    longint v;
    v = longint'(w[17:0]);
    if (w[17]) v = v - 262144;
    return v;
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_step();
    bit     old_v, hs, newres;
    longint res;
    if (areset) begin
      md_mode = 0; md_sum = 0; md_n = 0; md_beat = 0;
      md_ov = 0; md_od = '0; md_ol = 0; md_ovr = 0; md_drops = 0;
      md_pen = 0;
      return;
    end
    old_v  = md_ov;
    hs     = md_ov && m_axis_tready;
    newres = 0;
    res    = 0;
    if (md_mode == 1 && cfg_enable) begin
      if (s_axis_tvalid) begin
        md_sum += sx18(s_axis_tdata);
        md_n++;
        if (md_n == (1 << md_l)) begin
          res = floor_div(md_sum, longint'(1) << md_l);
          newres = 1; md_sum = 0; md_n = 0;
        end
      end
    end else begin
      md_sum = 0; md_n = 0;
    end
    if (hs) begin
      md_ov = 0;
      dlv_data.push_back(md_od);
      dlv_last.push_back(md_ol);
    end
    if (newres) begin
      if (!old_v || hs) begin
        md_ov = 1;
        md_od = 32'(res);
        md_ol = (md_beat == md_pkt - 1);
        md_beat = md_ol ? 0 : md_beat + 1;
      end else begin
        md_ovr = 1;
        md_drops++;
      end
    end
    case (md_mode)
      0: if (cfg_enable && !md_pen) begin
        md_mode = 1;
        md_l = (int'(cfg_log2_decim) > 8) ? 8 : int'(cfg_log2_decim);
        md_pkt = (cfg_pkt_len == 0) ? 1 : int'(cfg_pkt_len);
        md_beat = 0; md_ovr = 0; md_drops = 0;
      end
      1: if (!cfg_enable) md_mode = (old_v && !m_axis_tready) ? 2 : 0;
      default: if (!old_v) md_mode = 0;
    endcase
    md_pen = cfg_enable;
  endtask

  always @(posedge aclk) begin
    model_step();
    #1;
    chk("s_tready", 64'(s_axis_tready), 64'(!areset));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(md_ov));
    chk("overrun", 64'(overrun), 64'(md_ovr));
`ifdef ADC_DECIM_STATS_EN
    chk("drop_count", 64'(drop_count), 64'(md_drops));
`endif
    if (md_ov) begin
      chk("m_tdata", 64'(m_axis_tdata), 64'(md_od));
      chk("m_tlast", 64'(m_axis_tlast), 64'(md_ol));
    end
  end

  task automatic send(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  task automatic stop_and_wait();
    cfg_enable = 1'b0;
    for (int i = 0; i < 100 && md_mode != 0; i++) @(negedge aclk);
    chk("idle_reached", 64'(md_mode), 64'd0);
    idle(1);
  endtask

  task automatic start(input logic [3:0] l, input logic [15:0] p);
    cfg_enable = 1'b0;
    @(negedge aclk);
    cfg_log2_decim = l;
    cfg_pkt_len    = p;
    cfg_enable     = 1'b1;
    @(negedge aclk);
  endtask

  task automatic expect_beat(input string name, input int idx, input logic [31:0] d, input bit l);
    if (idx >= dlv_data.size()) begin
      chk({name, "_present"}, 64'(dlv_data.size()), 64'(idx + 1));
    end else begin
      chk({name, "_data"}, 64'(dlv_data[idx]), 64'(d));
      chk({name, "_last"}, 64'(dlv_last[idx]), 64'(l));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    areset = 1'b0;
    idle(1);
    chk("post_rst_s_tready", 64'(s_axis_tready), 64'd1);

    // 1: L=2, pkt 4, inputs 1..16
    dlv_data.delete(); dlv_last.delete();
    m_axis_tready = 1'b1;
    start(4'd2, 16'd4);
    for (int i = 1; i <= 16; i++) send(32'(i));
    idle(3);
    chk("t1_count", 64'(dlv_data.size()), 64'd4);
    expect_beat("t1_b0", 0, 32'd2, 1'b0);
    expect_beat("t1_b1", 1, 32'd6, 1'b0);
    expect_beat("t1_b2", 2, 32'd10, 1'b0);
    expect_beat("t1_b3", 3, 32'd14, 1'b1);
    stop_and_wait();

    // 2: negative floor and full-scale window
    dlv_data.delete(); dlv_last.delete();
    start(4'd1, 16'd1);
    send(32'h0003FFFD);
    send(32'h0003FFFE);
    idle(3);
    expect_beat("t2_neg", 0, 32'hFFFFFFFD, 1'b1);
    stop_and_wait();
    dlv_data.delete(); dlv_last.delete();
    start(4'd8, 16'd1);
    for (int i = 0; i < 256; i++) send(32'h0001FFFF);
    idle(3);
    expect_beat("t2_full", 0, 32'h0001FFFF, 1'b1);
    stop_and_wait();

    // 3: stall with L=0
    dlv_data.delete(); dlv_last.delete();
    m_axis_tready = 1'b0;
    start(4'd0, 16'd4);
    send(32'd7); send(32'd8); send(32'd9);
    idle(1);
    chk("t3_held", 64'(m_axis_tdata), 64'd7);
    chk("t3_overrun", 64'(overrun), 64'd1);
`ifdef ADC_DECIM_STATS_EN
    chk("t3_drops", 64'(drop_count), 64'd2);
`endif
    m_axis_tready = 1'b1;
    idle(1);
    m_axis_tready = 1'b0;
    idle(1);
    chk("t3_one_beat", 64'(dlv_data.size()), 64'd1);
    m_axis_tready = 1'b1;
    send(32'd10); send(32'd11); send(32'd12);
    idle(2);
    expect_beat("t3_b0", 0, 32'd7, 1'b0);
    expect_beat("t3_b3", 3, 32'd12, 1'b1);
    stop_and_wait();

    // 4: result coincides with handshake
    dlv_data.delete(); dlv_last.delete();
    start(4'd0, 16'd8);
    for (int i = 0; i < 20; i++) send(32'(100 + i));
    idle(2);
    chk("t4_overrun", 64'(overrun), 64'd0);
    chk("t4_count", 64'(dlv_data.size()), 64'd20);
    stop_and_wait();

    // 5: stop mid-window with a stalled beat
    dlv_data.delete(); dlv_last.delete();
    m_axis_tready = 1'b0;
    start(4'd2, 16'd4);
    send(32'd4); send(32'd4); send(32'd4); send(32'd4);
    send(32'd9); send(32'd9);
    cfg_enable = 1'b0;
    idle(3);
    chk("t5_pending", 64'(m_axis_tvalid), 64'd1);
    chk("t5_pending_data", 64'(m_axis_tdata), 64'd4);
    m_axis_tready = 1'b1;
    stop_and_wait();
    chk("t5_count", 64'(dlv_data.size()), 64'd1);
    expect_beat("t5_drain", 0, 32'd4, 1'b0);
    start(4'd0, 16'd2);
    send(32'd1); send(32'd2);
    idle(2);
    expect_beat("t5_r0", 1, 32'd1, 1'b0);
    expect_beat("t5_r1", 2, 32'd2, 1'b1);
    stop_and_wait();

    // 6: reset while streaming, then clamp of L=15
    m_axis_tready = 1'b0;
    start(4'd0, 16'd4);
    send(32'd5); send(32'd6);
    areset = 1'b1; cfg_enable = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'd7;
    @(negedge aclk);
    chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_tlast", 64'(m_axis_tlast), 64'd0);
    chk("t6_tdata", 64'(m_axis_tdata), 64'd0);
    chk("t6_overrun", 64'(overrun), 64'd0);
    areset = 1'b0; s_axis_tvalid = 1'b0;
    idle(1);
    dlv_data.delete(); dlv_last.delete();
    m_axis_tready = 1'b1;
    start(4'd15, 16'd0);
    for (int i = 0; i < 256; i++) send(32'hABC00003);
    idle(3);
    chk("t6_clamp_count", 64'(dlv_data.size()), 64'd1);
    expect_beat("t6_clamp", 0, 32'd3, 1'b1);
    stop_and_wait();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) == 0) cfg_enable = !cfg_enable;
      cfg_log2_decim = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
      cfg_pkt_len    = 16'($urandom_range(5));
      s_axis_tvalid  = 1'($urandom_range(1));
      s_axis_tdata   = $urandom;
      m_axis_tready  = ($urandom_range(3) != 0);
      areset         = ($urandom_range(499) == 0);
      @(negedge aclk);
    end
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    stop_and_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
